// File: rtl/i2s_master_ctrl_pkg.sv
// Helper functions shared by the I2S master controller and its prescaler.
package i2s_master_ctrl_pkg;

  // Terminal value of the 8-bit sck divider for a given half-period length.
  function automatic logic [7:0] div_last(input int unsigned d);
    return 8'(d - 1);
  endfunction

  // Terminal value of the 5-bit bit-in-slot counter for a given slot width.
  function automatic logic [4:0] bit_last(input int unsigned f);
    return 5'(f - 1);
  endfunction

  // Length of one stereo frame in clk cycles.
  function automatic int unsigned frame_clks(input int unsigned d, input int unsigned f);
    return 4 * d * f;
  endfunction

endpackage

// File: rtl/i2s_master_ctrl_sck_prescaler.sv
// sck generator: divides clk by 2*div while active.
// It emits registered rise/fall strobes alongside sck and a combinational
// "falling now" flag so the parent can move ws in the same edge.
module sck_prescaler
  import i2s_master_ctrl_pkg::*;
#(
  parameter int unsigned div = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_quiet_fall,
  output logic o_sck,
  output logic o_rise_stb,
  output logic o_fall_stb,
  output logic o_fall_now
);

  localparam int unsigned            DCNT_W    = 8;
  localparam logic [DCNT_W-1:0]      DCNT_LAST = div_last(div);

  logic [DCNT_W-1:0] r_dcnt     = '0;
  logic              r_sck      = 1'b0;
  logic              r_rise_stb = 1'b0;
  logic              r_fall_stb = 1'b0;
  logic              w_wrap;

  assign w_wrap     = i_active && (r_dcnt == DCNT_LAST);
  assign o_fall_now = w_wrap && r_sck;
  assign o_sck      = r_sck;
  assign o_rise_stb = r_rise_stb;
  assign o_fall_stb = r_fall_stb;

  // Divider count, sck toggle on wrap, and edge strobes; the frame-ending fall is kept quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dcnt     <= '0;
      r_sck      <= 1'b0;
      r_rise_stb <= 1'b0;
      r_fall_stb <= 1'b0;
    end else if (!i_active) begin
      r_dcnt     <= '0;
      r_sck      <= 1'b0;
      r_rise_stb <= 1'b0;
      r_fall_stb <= 1'b0;
    end else begin
      r_rise_stb <= w_wrap && !r_sck;
      r_fall_stb <= w_wrap && r_sck && !i_quiet_fall;
      if (w_wrap) begin
        r_dcnt <= '0;
        r_sck  <= ~r_sck;
      end else begin
        r_dcnt <= r_dcnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/i2s_master_ctrl.sv
// I2S master clock/word-select controller.
// It has three states: IDLE, RUN and DRAIN. Draining always finishes the
// current right slot, so a started frame is never cut short.
module i2s_master_ctrl
  import i2s_master_ctrl_pkg::*;
#(
  parameter int unsigned div = 4,
  parameter int unsigned fw  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic ws,
  output logic rise_stb,
  output logic fall_stb,
  output logic l_stb,
  output logic r_stb,
  output logic busy
);

  localparam int unsigned       BCNT_W    = 5;
  localparam logic [BCNT_W-1:0] BCNT_LAST = bit_last(fw);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state = S_IDLE;
  state_t            w_state_nxt;
  logic [BCNT_W-1:0] r_bcnt  = BCNT_LAST;
  logic              r_ws    = 1'b1;
  logic              r_l_stb = 1'b0;
  logic              r_r_stb = 1'b0;
  logic              w_busy;
  logic              w_fall_now;
  logic              w_last;
  logic              w_term;

  assign w_busy = (r_state != S_IDLE);
  assign w_last = (r_bcnt == BCNT_LAST);
  // Frame ends on the last fall of a right slot while draining and not re-enabled.
  assign w_term = (r_state == S_DRAIN) && !en && w_fall_now && w_last && r_ws;

  sck_prescaler #(
    .div(div)
  ) u_sck_prescaler (
    .clk         (clk),
    .rst         (rst),
    .i_active    (w_busy),
    .i_quiet_fall(w_term),
    .o_sck       (sck),
    .o_rise_stb  (rise_stb),
    .o_fall_stb  (fall_stb),
    .o_fall_now  (w_fall_now)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_RUN;
      S_RUN:   if (!en) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (en)          w_state_nxt = S_RUN;
        else if (w_term) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit counter and ws advance on sck falling edges; slot boundary toggles ws with a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt  <= BCNT_LAST;
      r_ws    <= 1'b1;
      r_l_stb <= 1'b0;
      r_r_stb <= 1'b0;
    end else begin
      r_l_stb <= 1'b0;
      r_r_stb <= 1'b0;
      if (!w_busy) begin
        r_bcnt <= BCNT_LAST;
        r_ws   <= 1'b1;
      end else if (w_fall_now) begin
        if (w_term) begin
          r_bcnt <= BCNT_LAST;
        end else if (w_last) begin
          r_bcnt  <= '0;
          r_ws    <= ~r_ws;
          r_l_stb <= r_ws;
          r_r_stb <= ~r_ws;
        end else begin
          r_bcnt <= r_bcnt + 5'd1;
        end
      end
    end
  end

  assign ws    = r_ws;
  assign l_stb = r_l_stb;
  assign r_stb = r_r_stb;
  assign busy  = w_busy;

endmodule

// File: tb/tb_i2s_master_ctrl.sv
// Testbench for i2s_master_ctrl: three instances (div2/fw4, div3/fw16, div1/fw2).
module tb_i2s_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: div=2, fw=4
  logic rst_a = 1'b1, en_a = 1'b0;
  logic sck_a, ws_a, rise_a, fall_a, l_a, r_a, busy_a;
  i2s_master_ctrl #(.div(2), .fw(4)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .sck(sck_a), .ws(ws_a),
    .rise_stb(rise_a), .fall_stb(fall_a), .l_stb(l_a), .r_stb(r_a), .busy(busy_a));

  // Instance B: div=3, fw=16
  logic rst_b = 1'b1, en_b = 1'b0;
  logic sck_b, ws_b, rise_b, fall_b, l_b, r_b, busy_b;
  i2s_master_ctrl #(.div(3), .fw(16)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .sck(sck_b), .ws(ws_b),
    .rise_stb(rise_b), .fall_stb(fall_b), .l_stb(l_b), .r_stb(r_b), .busy(busy_b));

  // Instance C: div=1, fw=2
  logic rst_c = 1'b1, en_c = 1'b0;
  logic sck_c, ws_c, rise_c, fall_c, l_c, r_c, busy_c;
  i2s_master_ctrl #(.div(1), .fw(2)) dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .sck(sck_c), .ws(ws_c),
    .rise_stb(rise_c), .fall_stb(fall_c), .l_stb(l_c), .r_stb(r_c), .busy(busy_c));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard of expected ws strobes on instance A: kind 0 = left, 1 = right.
  typedef struct {
    int kind;
    int t;
  } ev_t;
  ev_t sbq[$];
  ev_t mon_e;

  // Vector table for instance A, times relative to RUN entry.
  // exp = {sck, ws, busy, rise, fall, l, r}; en_after is driven after the row is checked.
  typedef struct {
    int         t;
    logic       en_after;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[16];

  task automatic fill_table();
    tbl[0]  = '{0,  1'b1, 7'b0110000};
    tbl[1]  = '{1,  1'b1, 7'b0110000};
    tbl[2]  = '{2,  1'b1, 7'b1111000};
    tbl[3]  = '{3,  1'b1, 7'b1110000};
    tbl[4]  = '{4,  1'b1, 7'b0010110};
    tbl[5]  = '{6,  1'b1, 7'b1011000};
    tbl[6]  = '{8,  1'b1, 7'b0010100};
    tbl[7]  = '{20, 1'b1, 7'b0110101};
    tbl[8]  = '{36, 1'b1, 7'b0010110};
    tbl[9]  = '{38, 1'b0, 7'b1011000};
    tbl[10] = '{48, 1'b0, 7'b0010100};
    tbl[11] = '{52, 1'b0, 7'b0110101};
    tbl[12] = '{66, 1'b0, 7'b1111000};
    tbl[13] = '{67, 1'b0, 7'b1110000};
    tbl[14] = '{68, 1'b0, 7'b0100000};
    tbl[15] = '{80, 1'b0, 7'b0100000};
  endtask

  // Release reset on A with en high, then walk the table (full frame, drain, idle).
  task automatic run_from_release();
    int r0;
    rst_a = 1'b0;
    r0 = cyc + 1;
    sbq.push_back('{0, r0 + 4});
    sbq.push_back('{1, r0 + 20});
    sbq.push_back('{0, r0 + 36});
    sbq.push_back('{1, r0 + 52});
    for (int i = 0; i < 16; i++) begin
      while (cyc - r0 < tbl[i].t) tick(1);
      check($sformatf("vec%0d", i), {sck_a, ws_a, busy_a, rise_a, fall_a, l_a, r_a}, tbl[i].exp);
      en_a = tbl[i].en_after;
    end
  endtask

  // Continuous protocol checks on instance A.
  logic prev_ws_a = 1'b1;
  always @(posedge clk) begin
    #1;
    if (rst_a) begin
      prev_ws_a = 1'b1;
    end else begin
      if (ws_a !== prev_ws_a) check("ws_moves_with_fall", fall_a, 1);
      prev_ws_a = ws_a;
      if (rise_a || fall_a) check("rise_fall_exclusive", rise_a & fall_a, 0);
      if (!busy_a) check("idle_no_strobes", {rise_a, fall_a, l_a, r_a}, 0);
      if (l_a || r_a) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ws_strobe: got l=%0b r=%0b at cycle %0d, expected none", l_a, r_a, cyc);
        end else begin
          mon_e = sbq.pop_front();
          check("ws_strobe_time", cyc, mon_e.t);
          check("ws_strobe_kind", {l_a, r_a}, (mon_e.kind == 1) ? 2'b01 : 2'b10);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, t, last_rise, last_ws, last_l, busy_drops;
    logic last_was_l;
    fill_table();
    en_a = 1'b1;
    tick(3);
    check("reset_state_a", {sck_a, ws_a, busy_a, rise_a, fall_a, l_a, r_a}, 7'b0100000);

    // Full frame with en held, then drop mid left slot and drain to IDLE.
    run_from_release();

    // Restart from IDLE, then async reset mid left slot between clock edges.
    en_a = 1'b1;
    r0 = cyc + 1;
    sbq.push_back('{0, r0 + 4});
    while (cyc - r0 < 10) tick(1);
    check("pre_reset_running", {busy_a, ws_a}, 2'b10);
    #2 rst_a = 1'b1;
    #1 check("async_reset", {sck_a, ws_a, busy_a, rise_a, fall_a, l_a, r_a}, 7'b0100000);
    tick(2);
    check("reset_held_idle", {sck_a, ws_a, busy_a}, 3'b010);
    run_from_release();
    check("scoreboard_drained", sbq.size(), 0);

    // Instance B: en pulsed low 5 clk mid right slot; timing must not move.
    rst_b = 1'b0;
    en_b = 1'b1;
    r0 = cyc + 1;
    last_rise = -1; last_ws = -1; last_l = -1; busy_drops = 0; last_was_l = 1'b0;
    for (int k = 0; k < 600; k++) begin
      tick(1);
      t = cyc - r0;
      if (t == 130) en_b = 1'b0;
      if (t == 135) en_b = 1'b1;
      if (!busy_b) busy_drops++;
      if (rise_b) begin
        if (last_rise < 0) check("b_first_rise", t, 3);
        else check("b_sck_period", t - last_rise, 6);
        last_rise = t;
      end
      if (l_b || r_b) begin
        if (last_ws < 0) begin
          check("b_first_lstb", {l_b, r_b, 30'(t)}, {2'b10, 30'd6});
        end else begin
          check("b_slot_len", t - last_ws, 96);
          check("b_ws_alternate", l_b, !last_was_l);
        end
        if (l_b) begin
          if (last_l >= 0) check("b_frame_len", t - last_l, 192);
          last_l = t;
        end
        last_ws = t;
        last_was_l = l_b;
      end
    end
    check("b_busy_held", busy_drops, 0);

    // Instance C: div=1, fw=2 closed-form waveform.
    rst_c = 1'b0;
    en_c = 1'b1;
    r0 = cyc + 1;
    for (int k = 0; k < 24; k++) begin
      logic [6:0] e;
      tick(1);
      t = cyc - r0;
      e[6] = (t % 2 == 1);
      e[5] = (t < 2) ? 1'b1 : (((t - 2) / 4) % 2 == 1);
      e[4] = 1'b1;
      e[3] = (t % 2 == 1);
      e[2] = (t >= 2) && (t % 2 == 0);
      e[1] = (t >= 2) && ((t - 2) % 8 == 0);
      e[0] = (t >= 6) && ((t - 6) % 8 == 0);
      check($sformatf("c_t%0d", t), {sck_c, ws_c, busy_c, rise_c, fall_c, l_c, r_c}, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_master_ctrl.md
I2S_MASTER_CTRL -- requirements
Module: i2s_master_ctrl

Interface
REQ-001 Parameter div, default 4: clk cycles per sck half-period; legal range 1..255.
REQ-002 Parameter fw, default 16: sck periods per channel slot; legal range 2..32.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  run request; level-sensitive.
REQ-006 sck  output  1  I2S continuous serial clock, registered.
REQ-007 ws  output  1  I2S word select, 0 = left slot, 1 = right slot, registered.
REQ-008 rise_stb  output  1  one-clk pulse in the cycle sck goes 0->1; receiver sample point.
REQ-009 fall_stb  output  1  one-clk pulse in the cycle sck goes 1->0; transmitter shift point.
REQ-010 l_stb  output  1  one-clk pulse in the cycle ws goes 1->0.
REQ-011 r_stb  output  1  one-clk pulse in the cycle ws goes 0->1.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 State machine SHALL have three states: IDLE, RUN, DRAIN.
REQ-014 IDLE: sck=0, ws=1, divider count=0, bit count=fw-1; no strobes.
REQ-015 IDLE->RUN when en=1 at a clk edge; busy rises the following cycle.
REQ-016 In RUN/DRAIN the divider SHALL count 0..div-1 and wrap; on wrap sck toggles in the same edge.
REQ-017 The first sck edge after leaving IDLE SHALL be a rising edge, div clk cycles after entering RUN.
REQ-018 sck period SHALL be exactly 2*div clk cycles with 50% duty; a stereo frame SHALL be 2*fw sck periods = 4*div*fw clk cycles.
REQ-019 On each sck falling edge: if bit count = fw-1, bit count -> 0 and ws toggles (with l_stb or r_stb); otherwise bit count increments.
REQ-020 ws SHALL change only in the same clk edge as an sck falling edge, giving the I2S one-bit MSB delay.
REQ-021 RUN->DRAIN when en=0; DRAIN->RUN when en=1, with no disturbance to sck/ws timing.
REQ-022 DRAIN->IDLE on the sck falling edge at which bit count = fw-1 and ws = 1 (end of right slot); that edge SHALL drive sck low and SHALL NOT toggle ws or emit l_stb.
REQ-023 If en falls and rises again within one slot, no frame SHALL be truncated.
REQ-024 Every started left slot SHALL be followed by a complete right slot before IDLE.
REQ-025 rise_stb/fall_stb SHALL be mutually exclusive and SHALL never assert in IDLE.
REQ-026 With div=1, sck SHALL toggle every clk cycle and strobes alternate every cycle.

Reset
REQ-027 rst=1 SHALL immediately force IDLE and sck=0, ws=1, all strobes=0, busy=0, counters to IDLE values, regardless of clk.
REQ-028 Reset asserted mid-frame SHALL abandon the frame without further strobes; after release, the block waits for en as from power-up.
REQ-029 Every register SHALL also carry the reset value as its initial value.

Structure
REQ-030 State encodings and counter widths SHALL be module-local constants; no shared package is required.
REQ-031 Divider counter width SHALL be 8 bits; bit counter width 5 bits.
REQ-032 One sub-module is natural: sck_prescaler (divider count, sck register, rise/fall strobes); the FSM, bit counter and ws live in i2s_master_ctrl.

Verification
REQ-033 div=2, fw=4, en held 1 from reset release -> first sck rise 2 clk after RUN, sck period 4 clk, l_stb at first fall, r_stb 16 clk later, l_stb every 32 clk.
REQ-034 div=2, fw=4, en dropped mid left slot -> remaining left slot and full right slot emitted, then IDLE with sck=0, ws=1, busy=0, no extra l_stb.
REQ-035 div=3, fw=16, en pulsed low for 5 clk mid right slot -> sck/ws periodicity unchanged (6 clk / 192 clk), busy stays 1.
REQ-036 div=1, fw=2 -> sck toggles every clk, ws toggles every 4 clk, rise_stb/fall_stb alternate, never coincident.
REQ-037 rst asserted between clk edges mid-frame -> outputs at reset values before next clk edge; restart with en produces exact REQ-033 timing.
REQ-038 Checker: ws changes only coincident with fall_stb; l_stb/r_stb strictly alternate; frame length always 4*div*fw clk.
